// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache flush sequencer: state encodings and default geometry.
package cache_pkg;

  localparam int DEF_SETS_LOG2 = 6;
  localparam int DEF_WAYS_LOG2 = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INV   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    CHECK = ST_CHECK,
    WB    = ST_WB,
    INV   = ST_INV,
    DONE  = ST_DONE
  } flush_state_e;

endpackage

// File: rtl/flush_idx_counter.sv
// Line index counter for the flush walk: hold, synchronous clear, increment, async active-low reset.
module flush_idx_counter #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_flush_ctrl.sv
// Walks every cache line, writing back dirty lines through a req/ready handshake before invalidating each.
module cache_flush_ctrl
  import cache_pkg::*;
#(
  parameter int SETS_LOG2 = DEF_SETS_LOG2,
  parameter int WAYS_LOG2 = DEF_WAYS_LOG2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_line_dirty,
  input  logic                           i_wb_ready,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [SETS_LOG2-1:0]           o_set_idx,
  output logic [WAYS_LOG2-1:0]           o_way_idx,
  output logic                           o_tag_rd_en,
  output logic                           o_wb_req,
  output logic                           o_inv_en,
  output logic [SETS_LOG2+WAYS_LOG2:0]   o_wb_count
);

  localparam int N = SETS_LOG2 + WAYS_LOG2;

  flush_state_e r_state;
  logic [N:0]   r_wb_count;
  logic [N-1:0] w_idx;
  logic         w_clr;
  logic         w_inc;
  logic         w_last;

  assign w_last = (w_idx == {N{1'b1}});
  assign w_clr  = (r_state == IDLE) && i_start;
  assign w_inc  = (r_state == INV) && !w_last;

  flush_idx_counter #(.WIDTH(N)) u_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_count (w_idx)
  );

  // wb_count is cleared only by an accepted start, so it still reports the last flush while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_wb_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= READ;
            r_wb_count <= '0;
          end
        end
        READ:  r_state <= CHECK;
        CHECK: r_state <= i_line_dirty ? WB : INV;
        WB: begin
          if (i_wb_ready) begin
            r_state    <= INV;
            r_wb_count <= r_wb_count + (N+1)'(1);
          end
        end
        INV:     r_state <= w_last ? DONE : READ;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_tag_rd_en = (r_state == READ);
  assign o_wb_req    = (r_state == WB);
  assign o_inv_en    = (r_state == INV);
  assign o_way_idx   = w_idx[WAYS_LOG2-1:0];
  assign o_set_idx   = w_idx[N-1:WAYS_LOG2];
  assign o_wb_count  = r_wb_count;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl with 4 sets x 2 ways; a per-cycle trace model drives the comparisons.
module tb_cache_flush_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       lineDirty;
  logic       wbReady;
  logic       busy;
  logic       done;
  logic [1:0] setIdx;
  logic       wayIdx;
  logic       tagRdEn;
  logic       wbReq;
  logic       invEn;
  logic [3:0] wbCount;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  dirtyMask;
  int          stallCyc [8];
  logic [11:0] expQ [$];
  logic        dirtyHold;
  int          wbWait;
  int          busyCycles;
  int          wbReqCycles;
  int          doneCount;
  logic [2:0]  firstWbIdx;
  logic        wbSeen;

  cache_flush_ctrl #(.SETS_LOG2(2), .WAYS_LOG2(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_line_dirty (lineDirty),
    .i_wb_ready   (wbReady),
    .o_busy       (busy),
    .o_done       (done),
    .o_set_idx    (setIdx),
    .o_way_idx    (wayIdx),
    .o_tag_rd_en  (tagRdEn),
    .o_wb_req     (wbReq),
    .o_inv_en     (invEn),
    .o_wb_count   (wbCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mkExp(input logic b, input logic d, input logic r, input logic w,
                                        input logic v, input logic [2:0] ix, input logic [3:0] c);
    return {b, d, r, w, v, ix, c};
  endfunction

  // Memory-side responder: dirty bit follows a tag read for exactly one cycle, ready after the configured stall.
  always @(negedge clk) begin
    if (tagRdEn) begin
      lineDirty = dirtyMask[{setIdx, wayIdx}];
      dirtyHold = 1'b1;
    end else if (dirtyHold) begin
      dirtyHold = 1'b0;
    end else begin
      lineDirty = 1'($urandom);
    end
    if (wbReq) begin
      wbReady = (wbWait >= stallCyc[{setIdx, wayIdx}]);
      wbWait++;
    end else begin
      wbWait  = 0;
      wbReady = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    if (busy) busyCycles++;
    if (done) doneCount++;
    if (wbReq) begin
      wbReqCycles++;
      if (!wbSeen) begin
        wbSeen     = 1'b1;
        firstWbIdx = {setIdx, wayIdx};
      end
    end
  end

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput("trace", {busy, done, tagRdEn, wbReq, invEn, setIdx, wayIdx, wbCount}, expQ.pop_front());
    end
  end

  task automatic applyStimulus(input int restartAt, input int expBusy, input int expWbReq,
                               input int expWbCount);
    int cnt;
    int cyc;
    busyCycles  = 0;
    wbReqCycles = 0;
    doneCount   = 0;
    wbSeen      = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back(mkExp(1, 0, 1, 0, 0, 3'(i), 4'(cnt)));
      expQ.push_back(mkExp(1, 0, 0, 0, 0, 3'(i), 4'(cnt)));
      if (dirtyMask[i]) begin
        for (int k = 0; k <= stallCyc[i]; k++) expQ.push_back(mkExp(1, 0, 0, 1, 0, 3'(i), 4'(cnt)));
        cnt++;
      end
      expQ.push_back(mkExp(1, 0, 0, 0, 1, 3'(i), 4'(cnt)));
    end
    expQ.push_back(mkExp(1, 1, 0, 0, 0, 3'd7, 4'(cnt)));
    expQ.push_back(mkExp(0, 0, 0, 0, 0, 3'd7, 4'(cnt)));
    cyc = 0;
    while (expQ.size() > 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restartAt);
    end
    start = 1'b0;
    if (expQ.size() > 0) begin
      checkOutput("flushTimeout", 32'(expQ.size()), 0);
      expQ.delete();
    end
    @(negedge clk);
    checkOutput("busyCycles", 32'(busyCycles), 32'(expBusy));
    checkOutput("wbReqCycles", 32'(wbReqCycles), 32'(expWbReq));
    checkOutput("doneCount", 32'(doneCount), 1);
    checkOutput("wbCountFinal", 32'(wbCount), 32'(expWbCount));
  endtask

  initial begin
    int cyc;
    rstN      = 1'b0;
    start     = 1'b1;
    lineDirty = 1'b0;
    wbReady   = 1'b0;
    dirtyHold = 1'b0;
    wbWait    = 0;
    dirtyMask = 8'h00;
    for (int i = 0; i < 8; i++) stallCyc[i] = 0;

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {busy, done, tagRdEn, wbReq, invEn, setIdx, wayIdx, wbCount}, 0);
    start = 1'b0;
    rstN  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleAfterReset", {busy, wbCount}, 0);

    $display("[TB] all clean");
    applyStimulus(0, 25, 0, 0);

    $display("[TB] two dirty no stall");
    dirtyMask = 8'b0010_1000;
    applyStimulus(0, 27, 2, 2);
    checkOutput("firstWbLine", 32'(firstWbIdx), 32'h3);

    $display("[TB] write-back stall");
    dirtyMask   = 8'b0000_0001;
    stallCyc[0] = 4;
    applyStimulus(0, 30, 5, 1);
    checkOutput("stallWbLine", 32'(firstWbIdx), 32'h0);

    $display("[TB] start while busy");
    stallCyc[0] = 0;
    dirtyMask   = 8'b0100_0000;
    stallCyc[6] = 2;
    applyStimulus(5, 28, 3, 1);
    checkOutput("restartWbLine", 32'(firstWbIdx), 32'h6);

    $display("[TB] reset mid write-back");
    stallCyc[6] = 0;
    dirtyMask   = 8'b0000_0100;
    stallCyc[2] = 1000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!wbReq && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reachedWb", {wbReq, setIdx, wayIdx}, {1'b1, 3'd2});
    repeat (2) @(negedge clk);
    doneCount = 0;
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("wbReqAsyncDrop", {wbReq, busy}, 0);
    checkOutput("idxAsyncClear", {setIdx, wayIdx, wbCount}, 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("noDoneAfterReset", 32'(doneCount), 0);

    stallCyc[2] = 0;
    dirtyMask   = 8'h00;
    applyStimulus(0, 25, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
